// File: rtl/gb_mem_pkg.sv
// Shared types and constants for the Game Boy memory-side blocks.
package gb_mem_pkg;

  // OAM DMA engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam int unsigned OAM_SIZE       = 160;
  localparam logic [7:0]  ECHO_OFFSET_HI = 8'h20;
  localparam logic [7:0]  ECHO_START_HI  = 8'hE0;

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so fold high source pages down.
  function automatic logic [7:0] eff_src_hi(input logic [7:0] hi);
    return (hi >= ECHO_START_HI) ? (hi - ECHO_OFFSET_HI) : hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine and memory bus owner.
// A CPU write to the DMA register copies DMA_LEN bytes from {src_hi,00} into OAM.
// While copying, the engine owns both memory ports; otherwise CPU accesses pass through.
// Optional build macro OAM_DMA_BUS_CONFLICT_EN: blocked CPU reads return the byte on the
// DMA read bus instead of 8'hFF.
module oam_dma
  import gb_mem_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = gb_mem_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_BASE     = gb_mem_pkg::OAM_BASE,
  parameter int unsigned DMA_LEN      = gb_mem_pkg::OAM_SIZE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_rd_addr,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [7:0]  o_cpu_rd_data,
  output logic [15:0] o_mem_rd_addr,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_dma_active
);

  localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

  dma_state_t r_state, w_state_d;
  logic [7:0] r_idx, w_idx_d;
  logic [7:0] r_src_hi, w_src_hi_d;
  logic       r_cpu_rd_blocked;

  logic        w_trigger;
  logic [15:0] w_src_addr;
  logic [15:0] w_oam_addr;

  assign w_trigger  = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);
  assign w_src_addr = {eff_src_hi(r_src_hi), 8'h00} + {8'h00, r_idx};
  // The write trails the read by one cycle, so it targets the previous index.
  assign w_oam_addr = OAM_BASE + {8'h00, r_idx} - 16'd1;

  // State, index and source-page registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_idx            <= 8'h00;
      r_src_hi         <= 8'h00;
      r_cpu_rd_blocked <= 1'b0;
    end else begin
      r_state          <= w_state_d;
      r_idx            <= w_idx_d;
      r_src_hi         <= w_src_hi_d;
      r_cpu_rd_blocked <= (r_state == XFER);
    end
  end

  // Next-state logic; a DMA register write (re)starts the transfer from any state.
  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_src_hi_d = r_src_hi;
    unique case (r_state)
      IDLE: ;
      XFER: begin
        w_idx_d = r_idx + 8'd1;
        if (r_idx == LastIdx) w_state_d = DRAIN;
      end
      DRAIN: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (w_trigger) begin
      w_state_d  = XFER;
      w_idx_d    = 8'h00;
      w_src_hi_d = i_cpu_wr_data;
    end
  end

  // Memory port steering: CPU pass-through in IDLE, DMA ownership otherwise.
  always_comb begin
    o_mem_rd_addr = i_cpu_rd_addr;
    o_mem_wr_en   = i_cpu_wr_en;
    o_mem_wr_addr = i_cpu_wr_addr;
    o_mem_wr_data = i_cpu_wr_data;
    unique case (r_state)
      IDLE: ;
      XFER: begin
        o_mem_rd_addr = w_src_addr;
        // No read data is available yet in the first cycle after (re)start.
        o_mem_wr_en   = (r_idx != 8'h00);
        o_mem_wr_addr = w_oam_addr;
        o_mem_wr_data = i_mem_rd_data;
      end
      DRAIN: begin
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = w_oam_addr;
        o_mem_wr_data = i_mem_rd_data;
      end
      default: o_mem_wr_en = 1'b0;
    endcase
    if (i_rst) o_mem_wr_en = 1'b0;
  end

  assign o_dma_active = (r_state == XFER) || (r_state == DRAIN);

`ifdef OAM_DMA_BUS_CONFLICT_EN
  // Blocked reads see whatever byte the DMA is moving.
  assign o_cpu_rd_data = i_mem_rd_data;
`else
  assign o_cpu_rd_data = r_cpu_rd_blocked ? 8'hFF : i_mem_rd_data;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma with a 64 KiB registered-read memory model.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_cpu_rd_addr;
  logic        i_cpu_wr_en;
  logic [15:0] i_cpu_wr_addr;
  logic [7:0]  i_cpu_wr_data;
  logic [7:0]  o_cpu_rd_data;
  logic [15:0] o_mem_rd_addr;
  logic        o_mem_wr_en;
  logic [15:0] o_mem_wr_addr;
  logic [7:0]  o_mem_wr_data;
  logic [7:0]  mem_rd_q;
  logic        o_dma_active;

  logic [7:0] mem [0:65535];
  logic [7:0] exp_oam [0:159];
  logic [7:0] prior [0:159];

  int tests = 0;
  int fails = 0;
  int act_cnt = 0;

  always #5 clk = ~clk;

  oam_dma dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_cpu_rd_addr(i_cpu_rd_addr),
    .i_cpu_wr_en  (i_cpu_wr_en),
    .i_cpu_wr_addr(i_cpu_wr_addr),
    .i_cpu_wr_data(i_cpu_wr_data),
    .o_cpu_rd_data(o_cpu_rd_data),
    .o_mem_rd_addr(o_mem_rd_addr),
    .o_mem_wr_en  (o_mem_wr_en),
    .o_mem_wr_addr(o_mem_wr_addr),
    .o_mem_wr_data(o_mem_wr_data),
    .i_mem_rd_data(mem_rd_q),
    .o_dma_active (o_dma_active)
  );

  // Memory array: registered read of the old contents, then write.
  always @(posedge clk) begin
    mem_rd_q <= mem[o_mem_rd_addr];
    if (o_mem_wr_en) mem[o_mem_wr_addr] = o_mem_wr_data;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; count cycles in which the engine is active.
  task automatic tick;
    @(posedge clk);
    #1;
    if (o_dma_active) act_cnt++;
  endtask

  task automatic wait_idle;
    int g = 0;
    while (o_dma_active && g < 1000) begin
      tick;
      g++;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    i_cpu_wr_en   = 1'b1;
    i_cpu_wr_addr = a;
    i_cpu_wr_data = d;
    tick;
    i_cpu_wr_en   = 1'b0;
  endtask

  // Expected OAM image: 160 bytes from the (echo-folded) source page.
  task automatic snap(input logic [7:0] hi);
    int page = (int'(hi) >= 224) ? int'(hi) - 32 : int'(hi);
    for (int i = 0; i < 160; i++) exp_oam[i] = mem[page * 256 + i];
  endtask

  task automatic check_oam(input string tag);
    for (int i = 0; i < 160; i++)
      check($sformatf("%s_oam[%0d]", tag, i), {8'h00, mem[16'hFE00 + i]}, {8'h00, exp_oam[i]});
  endtask

  initial begin
    logic [7:0] hi;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    mem[16'h0150] = 8'h3C;
    mem[16'hC000] = 8'h00;
    mem[16'h8000] = 8'h11;

    // Reset, with a CPU write held during it that must not reach memory.
    i_rst = 1'b1;
    i_cpu_rd_addr = 16'h0000;
    i_cpu_wr_en = 1'b1;
    i_cpu_wr_addr = 16'h8000;
    i_cpu_wr_data = 8'h55;
    tick;
    tick;
    check("rst_active", {15'd0, o_dma_active}, 16'd0);
    check("rst_wr_en", {15'd0, o_mem_wr_en}, 16'd0);
    i_cpu_wr_en = 1'b0;
    i_rst = 1'b0;
    tick;
    check("rst_no_write", {8'h00, mem[16'h8000]}, 16'h0011);

    // Idle pass-through of reads and writes.
    i_cpu_rd_addr = 16'h0150;
    tick;
    check("idle_rd", {8'h00, o_cpu_rd_data}, 16'h003C);
    cpu_write(16'h8001, 8'hA5);
    tick;
    check("idle_wr", {8'h00, mem[16'h8001]}, 16'h00A5);

    // Basic transfer from C100 with blocked read and dropped write.
    snap(8'hC1);
    act_cnt = 0;
    cpu_write(16'hFF46, 8'hC1);                     // now in cycle T+1
    check("t1_active_start", {15'd0, o_dma_active}, 16'd1);
    repeat (9) tick;                                // cycle T+10
    i_cpu_rd_addr = 16'h0150;
    tick;                                           // cycle T+11
`ifdef OAM_DMA_BUS_CONFLICT_EN
    check("t1_blocked_rd", {8'h00, o_cpu_rd_data}, {8'h00, exp_oam[9]});
`else
    check("t1_blocked_rd", {8'h00, o_cpu_rd_data}, 16'h00FF);
`endif
    repeat (9) tick;                                // cycle T+20
    cpu_write(16'hC000, 8'h12);
    wait_idle;
    check("t1_active_cycles", 16'(act_cnt), 16'd161);
    check_oam("t1");
    check("t1_reg_mem", {8'h00, mem[16'hFF46]}, 16'h00C1);
    check("t1_dropped_wr", {8'h00, mem[16'hC000]}, 16'h0000);
    tick;
    check("t1_post_rd", {8'h00, o_cpu_rd_data}, 16'h003C);

    // Restart at T+50 with a new source page.
    snap(8'hC2);
    act_cnt = 0;
    cpu_write(16'hFF46, 8'hC1);
    repeat (49) tick;                               // cycle T+50
    cpu_write(16'hFF46, 8'hC2);
    wait_idle;
    check("t2_active_cycles", 16'(act_cnt), 16'd211);
    check_oam("t2");
    check("t2_reg_mem", {8'h00, mem[16'hFF46]}, 16'h00C1);

    // Echo-mirror source: FE folds to DE.
    snap(8'hFE);
    act_cnt = 0;
    cpu_write(16'hFF46, 8'hFE);
    wait_idle;
    check("t3_active_cycles", 16'(act_cnt), 16'd161);
    check_oam("t3");

    // Reset after 79 bytes have been written aborts the rest.
    for (int i = 0; i < 160; i++) begin
      mem[16'hFE00 + i] = 8'($urandom);
      prior[i] = mem[16'hFE00 + i];
    end
    hi = 8'($urandom_range(0, 255));
    snap(hi);
    cpu_write(16'hFF46, hi);                        // cycle T+1
    repeat (80) tick;                               // cycle T+81: byte 79 pending
    i_rst = 1'b1;
    #1;
    check("t4_rst_wr_en", {15'd0, o_mem_wr_en}, 16'd0);
    tick;
    check("t4_rst_active", {15'd0, o_dma_active}, 16'd0);
    check("t4_rst_wr_en_after", {15'd0, o_mem_wr_en}, 16'd0);
    i_rst = 1'b0;
    tick;
    check("t4_idle_after", {15'd0, o_dma_active}, 16'd0);
    for (int i = 0; i < 160; i++)
      check($sformatf("t4_oam[%0d]", i), {8'h00, mem[16'hFE00 + i]},
            {8'h00, (i <= 78) ? exp_oam[i] : prior[i]});

    // Random source pages.
    for (int n = 0; n < 3; n++) begin
      hi = 8'($urandom_range(0, 255));
      snap(hi);
      act_cnt = 0;
      cpu_write(16'hFF46, hi);
      wait_idle;
      check($sformatf("r%0d_active_cycles", n), 16'(act_cnt), 16'd161);
      check_oam($sformatf("r%0d", n));
      check($sformatf("r%0d_reg_mem", n), {8'h00, mem[16'hFF46]}, {8'h00, hi});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
